// File: rtl/fft_frame_packer.sv
// fft_frame_packer: output stage of the FFT datapath.
// Collects 16 complex results (one per accepted beat) into a frame buffer,
// then presents the whole frame at once on fft_d0..fft_d15 with a one-cycle
// fft_valid strobe. Consecutive strobes are spaced at least GAP cycles apart
// so the downstream 16-cycle serial scan is never cut short.
//
// Parameters:
//   GAP    minimum cycles between fft_valid pulses (1..31)
//   GAP_W  width of the gap counter (must hold GAP-1)
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   in_valid         input beat valid
//   in_ready         packer can accept a beat (1 while filling, 0 while waiting)
//   in_data[31:0]    {real[15:0], imag[15:0]}, passed through unmodified
//   fft_valid        one-cycle frame strobe
//   fft_d0..fft_d15  frame words, index = frequency bin
//
// Build option:
//   BITREV_EN  defined: beats arrive in bit-reversed order and are written to
//              buf[bitrev4(i)], so fft_dN is in natural bin order.
//              undefined: beat i is written to buf[i].
module fft_frame_packer #(
  parameter int unsigned GAP   = 16,
  parameter int unsigned GAP_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        fft_valid,
  output logic [31:0] fft_d0,
  output logic [31:0] fft_d1,
  output logic [31:0] fft_d2,
  output logic [31:0] fft_d3,
  output logic [31:0] fft_d4,
  output logic [31:0] fft_d5,
  output logic [31:0] fft_d6,
  output logic [31:0] fft_d7,
  output logic [31:0] fft_d8,
  output logic [31:0] fft_d9,
  output logic [31:0] fft_d10,
  output logic [31:0] fft_d11,
  output logic [31:0] fft_d12,
  output logic [31:0] fft_d13,
  output logic [31:0] fft_d14,
  output logic [31:0] fft_d15
);

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_e;

  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP - 1);

  state_e            state_q,     state_d;
  logic [3:0]        wr_idx_q,    wr_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
  logic              fft_valid_q, fft_valid_d;
  logic [31:0]       buf_q   [16];
  logic [31:0]       buf_d   [16];
  logic [31:0]       fft_d_q [16];
  logic [31:0]       fft_d_d [16];
  logic [3:0]        slot;
  logic              gap_ok;

  always_comb begin
`ifdef BITREV_EN
    slot = {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2], wr_idx_q[3]};
`else
    slot = wr_idx_q;
`endif
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    buf_d       = buf_q;
    fft_d_d     = fft_d_q;
    fft_valid_d = 1'b0;
    gap_ok      = (gap_cnt_q == GAP_MAX);
    // Free-running counter saturating at GAP-1; cleared on a transfer below.
    gap_cnt_d   = gap_ok ? gap_cnt_q : gap_cnt_q + GAP_W'(1);
    in_ready    = (state_q == ST_FILL);

    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          buf_d[slot] = in_data;
          wr_idx_d    = wr_idx_q + 4'd1;
          if (wr_idx_q == 4'd15) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (gap_ok) begin
          fft_d_d     = buf_q;
          fft_valid_d = 1'b1;
          wr_idx_d    = '0;
          gap_cnt_d   = '0;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_idx_q    <= '0;
      gap_cnt_q   <= GAP_MAX;
      fft_valid_q <= 1'b0;
      buf_q       <= '{default: '0};
      fft_d_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      fft_valid_q <= fft_valid_d;
      buf_q       <= buf_d;
      fft_d_q     <= fft_d_d;
    end
  end

  assign fft_valid = fft_valid_q;
  assign fft_d0    = fft_d_q[0];
  assign fft_d1    = fft_d_q[1];
  assign fft_d2    = fft_d_q[2];
  assign fft_d3    = fft_d_q[3];
  assign fft_d4    = fft_d_q[4];
  assign fft_d5    = fft_d_q[5];
  assign fft_d6    = fft_d_q[6];
  assign fft_d7    = fft_d_q[7];
  assign fft_d8    = fft_d_q[8];
  assign fft_d9    = fft_d_q[9];
  assign fft_d10   = fft_d_q[10];
  assign fft_d11   = fft_d_q[11];
  assign fft_d12   = fft_d_q[12];
  assign fft_d13   = fft_d_q[13];
  assign fft_d14   = fft_d_q[14];
  assign fft_d15   = fft_d_q[15];

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed bench for fft_frame_packer. Instance "a" uses GAP=16, instance
// "b" uses GAP=20; both share clk and rst. Cycle c is the period after the
// c-th rising edge of a test; outputs are sampled and inputs driven at the
// falling edge in the middle of each cycle.
module tb_fft_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_fv;
  logic [31:0] a_data;
  logic [31:0] a_d [16];
  logic        b_valid, b_ready, b_fv;
  logic [31:0] b_data;
  logic [31:0] b_d [16];
  logic [31:0] exp_d [16];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_frame_packer #(.GAP(16), .GAP_W(5)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .fft_valid(a_fv),
    .fft_d0(a_d[0]),   .fft_d1(a_d[1]),   .fft_d2(a_d[2]),   .fft_d3(a_d[3]),
    .fft_d4(a_d[4]),   .fft_d5(a_d[5]),   .fft_d6(a_d[6]),   .fft_d7(a_d[7]),
    .fft_d8(a_d[8]),   .fft_d9(a_d[9]),   .fft_d10(a_d[10]), .fft_d11(a_d[11]),
    .fft_d12(a_d[12]), .fft_d13(a_d[13]), .fft_d14(a_d[14]), .fft_d15(a_d[15])
  );

  fft_frame_packer #(.GAP(20), .GAP_W(5)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .fft_valid(b_fv),
    .fft_d0(b_d[0]),   .fft_d1(b_d[1]),   .fft_d2(b_d[2]),   .fft_d3(b_d[3]),
    .fft_d4(b_d[4]),   .fft_d5(b_d[5]),   .fft_d6(b_d[6]),   .fft_d7(b_d[7]),
    .fft_d8(b_d[8]),   .fft_d9(b_d[9]),   .fft_d10(b_d[10]), .fft_d11(b_d[11]),
    .fft_d12(b_d[12]), .fft_d13(b_d[13]), .fft_d14(b_d[14]), .fft_d15(b_d[15])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_a(input string tag);
    for (int k = 0; k < 16; k++) check($sformatf("%s_a_d%0d", tag, k), a_d[k], exp_d[k]);
  endtask

  task automatic check_all_b(input string tag);
    for (int k = 0; k < 16; k++) check($sformatf("%s_b_d%0d", tag, k), b_d[k], exp_d[k]);
  endtask

  // Slot an input beat position lands in.
  function automatic int slot_of(input int i);
    logic [3:0] v;
    v = i[3:0];
`ifdef BITREV_EN
    return int'({v[0], v[1], v[2], v[3]});
`else
    return int'(v);
`endif
  endfunction

  initial begin
    int acc;
    logic exp_rdy;

    rst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;

    // Test 1: three reset cycles, then check the first post-reset cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) exp_d[k] = '0;
    check("t1_a_fv", 32'(a_fv), 32'd0);
    check("t1_a_rdy", 32'(a_ready), 32'd1);
    check_all_a("t1");
    check("t1_b_fv", 32'(b_fv), 32'd0);
    check("t1_b_rdy", 32'(b_ready), 32'd1);
    check_all_b("t1");

    // Test 2: single frame on a (GAP=16), in_data = k<<16.
    for (int c = 0; c <= 17; c++) begin
      check($sformatf("t2_fv_c%0d", c), 32'(a_fv), 32'(c == 17));
      check($sformatf("t2_rdy_c%0d", c), 32'(a_ready), 32'(c != 16));
      if (c == 17) begin
        for (int k = 0; k < 16; k++) exp_d[k] = 32'(k) << 16;
        check_all_a("t2");
      end
      a_valid = (c <= 15);
      a_data  = 32'(c) << 16;
      @(negedge clk);
    end
    a_valid = 1'b0;

    // Test 3: throttle on b (GAP=20), 32 beats offered continuously.
    acc = 0;
    for (int c = 0; c <= 40; c++) begin
      exp_rdy = !(c == 16 || (c >= 33 && c <= 36));
      check($sformatf("t3_fv_c%0d", c), 32'(b_fv), 32'(c == 17 || c == 37));
      check($sformatf("t3_rdy_c%0d", c), 32'(b_ready), 32'(exp_rdy));
      if (c == 17) begin
        for (int k = 0; k < 16; k++) exp_d[k] = 32'(k);
        check_all_b("t3f1");
      end
      if (c == 37) begin
        for (int k = 0; k < 16; k++) exp_d[k] = 32'(16 + k);
        check_all_b("t3f2");
      end
      b_valid = (acc < 32);
      b_data  = 32'(acc);
      if (b_valid && exp_rdy) acc++;
      @(negedge clk);
    end
    b_valid = 1'b0;

    // Test 4: bubbles on a, beats on even cycles 0..30, then 100 idle cycles.
    for (int c = 0; c <= 32; c++) begin
      check($sformatf("t4_fv_c%0d", c), 32'(a_fv), 32'(c == 32));
      check($sformatf("t4_rdy_c%0d", c), 32'(a_ready), 32'(c != 31));
      if (c == 32) begin
        for (int k = 0; k < 16; k++) exp_d[k] = 32'h0BEE_0000 + 32'(k);
        check_all_a("t4");
      end
      a_valid = (c <= 30) && (c % 2 == 0);
      a_data  = 32'h0BEE_0000 + 32'(c / 2);
      @(negedge clk);
    end
    a_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      check($sformatf("t4_idle_fv_c%0d", c), 32'(a_fv), 32'd0);
      @(negedge clk);
    end
    check_all_a("t4_hold");

    // Test 5: beat position i carries in_data = i; slot mapping per build.
    for (int c = 0; c <= 17; c++) begin
      check($sformatf("t5_fv_c%0d", c), 32'(a_fv), 32'(c == 17));
      check($sformatf("t5_rdy_c%0d", c), 32'(a_ready), 32'(c != 16));
      if (c == 17) begin
        for (int i = 0; i < 16; i++) exp_d[slot_of(i)] = 32'(i);
        check_all_a("t5");
      end
      a_valid = (c <= 15);
      a_data  = 32'(c);
      @(negedge clk);
    end
    a_valid = 1'b0;

    // Test 6: 7 beats, one reset cycle with a beat presented, then a full frame.
    for (int c = 0; c <= 30; c++) begin
      check($sformatf("t6_fv_c%0d", c), 32'(a_fv), 32'(c == 25));
      check($sformatf("t6_rdy_c%0d", c), 32'(a_ready), 32'(c != 24));
      if (c == 8) begin
        for (int k = 0; k < 16; k++) exp_d[k] = '0;
        check_all_a("t6_clr");
      end
      if (c == 25) begin
        for (int k = 0; k < 16; k++) exp_d[k] = 32'hA5A5_0000 + 32'(k);
        check_all_a("t6");
      end
      if (c < 7) begin
        rst = 1'b0; a_valid = 1'b1; a_data = 32'hDEAD_0000 + 32'(c);
      end else if (c == 7) begin
        rst = 1'b1; a_valid = 1'b1; a_data = 32'hBAD0_BAD0;
      end else begin
        rst = 1'b0; a_valid = (c <= 23); a_data = 32'hA5A5_0000 + 32'(c - 8);
      end
      @(negedge clk);
    end
    a_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_frame_packer.md
Name: fft_frame_packer

Overview:
Output stage of the FFT datapath, feeding the frequency analyser's parallel input bus.
- Accepts one complex FFT result per beat over a valid/ready stream.
- Assembles 16 results into a frame, then presents all 16 at once on fft_d0..fft_d15 with a one-cycle fft_valid pulse.
- Enforces a minimum spacing between fft_valid pulses so the downstream 16-cycle serial scan is never truncated.

Parameters:
GAP, 16, minimum cycles between consecutive fft_valid pulses (legal range 1..31)
GAP_W, 5, width of internal gap counter; must hold GAP-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  packer can accept a beat
in_data  input  32  complex sample: [31:16] real, [15:0] imag, signed two's complement (passed through unmodified)
fft_valid  output  1  one-cycle frame strobe
fft_d0..fft_d15  output  32 each  frame words, index = frequency bin

Behaviour:
- Interface timing: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - fft_valid=0 and all fft_dN=0.
  - State FILL, wr_idx=0, gap_cnt=GAP-1 (saturated, so the first frame is not throttled).
  - in_ready=1 in the first cycle after reset.
- Beat acceptance: a beat is accepted on an edge where in_valid and in_ready are both high. It is written to buf[slot], where slot=wr_idx (natural order), then wr_idx increments mod 16.
- in_ready is combinational from state only: 1 in FILL, 0 in WAIT. It never depends on in_valid.
- FILL state:
  - The 16th accepted beat (wr_idx==15) moves the FSM to WAIT at that edge.
  - Bubbles (in_valid=0) only stall; no timeout.
- WAIT state:
  - gap_ok = (gap_cnt == GAP-1).
  - On an edge in WAIT with gap_ok (the transfer edge): fft_dN <= buf[N] for all N, fft_valid <= 1, wr_idx <= 0, state <= FILL.
  - The FSM stays in WAIT while gap_ok=0.
- fft_valid: registered; high for exactly the one cycle after the transfer edge, 0 otherwise.
- fft_dN: change only on a transfer edge and hold between frames. The downstream block samples them only on fft_valid.
- gap_cnt:
  - Set to 0 on the transfer edge, so it reads 0 during the fft_valid cycle.
  - Otherwise increments each edge, saturating at GAP-1.
  - Result: pulses are at least GAP cycles apart.
- Latency: with gap satisfied, the 16th beat is accepted at the end of cycle t, the FSM is in WAIT in cycle t+1, and fft_valid is high in cycle t+2.
- Buffering: buf is single-buffered. New beats cannot be accepted until the transfer edge, since in_ready=0 in WAIT. in_ready returns to 1 in the fft_valid cycle.
- Reset mid-operation: a partial frame is discarded, outputs are cleared, and gap_cnt is re-saturated. Any beat presented in a reset cycle is dropped.
- There is no overflow or underflow condition; backpressure is the only flow control.

Optional Feature:
BITREV_EN
- Defined: input beats arrive in FFT bit-reversed order. Beat position i (0..15) is written to buf[bitrev4(i)], e.g. position 1->slot 8, 3->12, 6->6. fft_dN is therefore in natural bin order.
- Undefined: slot = i. Otherwise behaviour is identical, including timing.

Test Plan:
1. Reset: hold rst for 3 cycles, then release -> fft_valid=0, all fft_dN=0, in_ready=1 in the first post-reset cycle.
2. Single frame, natural order, GAP=16: beats k=0..15 in cycles 0..15 with in_data=k<<16 -> in_ready=0 in cycle 16; fft_valid=1 only in cycle 17 with fft_dk=k<<16; in_ready=1 in cycle 17.
3. Throttle, GAP=20: 32 beats offered continuously from cycle 0 ->
   - first fft_valid in cycle 17;
   - second frame's 16th beat accepted in cycle 32;
   - in_ready=0 in cycles 33..36;
   - second fft_valid in cycle 37, exactly 20 cycles after the first.
4. Bubbles: 16 beats with in_valid toggling 1/0 (beats on even cycles 0..30) -> no fft_valid before the 16th beat; fft_valid in cycle 32; fft_d0..fft_d15 hold their values through a later idle period of 100 cycles.
5. BITREV_EN: beats at positions i=0..15 with in_data=i -> fft_d1=8, fft_d8=1, fft_d3=12, fft_d6=6, fft_d15=15.
6. Reset mid-frame: 7 beats, rst for 1 cycle, then 16 beats of 0xA5A5_0000+k -> exactly one fft_valid, 2 cycles after the 16th post-reset beat is accepted; fft_dk=0xA5A5_0000+k; no contamination from the 7 pre-reset beats.
